// File: rtl/universal_shift_pkg.sv
// rtl/universal_shift_pkg.sv - shared mode constants and burst FSM state type
//
// Purpose: operation encodings for the universal shift register, the burst
// controller state enum, and a helper that tells which modes may run as a burst.
package universal_shift_pkg;

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_SHL  = 3'b001;
  localparam logic [2:0] MODE_SHR  = 3'b010;
  localparam logic [2:0] MODE_LOAD = 3'b011;
  localparam logic [2:0] MODE_ROL  = 3'b100;
  localparam logic [2:0] MODE_ROR  = 3'b101;
  localparam logic [2:0] MODE_CLR  = 3'b110;
  localparam logic [2:0] MODE_RSVD = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Only the four bit-moving operations make sense repeated autonomously.
  function automatic logic is_burst_mode(input logic [2:0] m);
    return (m == MODE_SHL) || (m == MODE_SHR) || (m == MODE_ROL) || (m == MODE_ROR);
  endfunction

endpackage

// File: rtl/shift_burst_ctrl.sv
// rtl/shift_burst_ctrl.sv - burst sequencer that selects the effective shift operation
//
// Purpose: owns the IDLE/SHIFT/DONE FSM, the captured burst mode and the step
// down-counter, and tells the datapath which operation to apply on each edge.
// Ports:
//   clk_i, rst_i     clock, async active-high reset
//   en_i             clock enable for direct operations and burst steps
//   mode_i           requested operation
//   start_i,count_i  burst request and number of steps
//   op_o             operation the register applies this edge (HOLD when idle/stalled)
//   busy_o, done_o   burst in progress / one-cycle completion pulse
module shift_burst_ctrl
  import universal_shift_pkg::*;
#(
  parameter int CW = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          en_i,
  input  logic [2:0]    mode_i,
  input  logic          start_i,
  input  logic [CW-1:0] count_i,
  output logic [2:0]    op_o,
  output logic          busy_o,
  output logic          done_o
);

  state_e        state_q, state_d;
  logic [2:0]    mode_q,  mode_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic          launch;

  // A burst is only launched from IDLE; the launch edge itself leaves pout untouched.
  assign launch = (state_q == ST_IDLE) && en_i && start_i &&
                  (count_i != '0) && is_burst_mode(mode_i);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_HOLD;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (launch) begin
          state_d = ST_SHIFT;
          mode_d  = mode_i;
          cnt_d   = count_i;
        end
      end
      ST_SHIFT: begin
        if (en_i) begin
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    op_o   = MODE_HOLD;
    busy_o = 1'b0;
    done_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (en_i && !launch) op_o = mode_i;
      end
      ST_SHIFT: begin
        busy_o = 1'b1;
        if (en_i) op_o = mode_q;
      end
      ST_DONE: done_o = 1'b1;
      default: op_o = MODE_HOLD;
    endcase
  end

endmodule

// File: rtl/universal_shift_reg.sv
// rtl/universal_shift_reg.sv - parametrised universal shift register with burst mode
//
// Purpose: WIDTH-bit register supporting hold, shift left/right, rotate
// left/right, parallel load and clear, plus autonomous multi-step bursts.
// Ports:
//   clk_i, rst_i         clock, async active-high reset
//   en_i                 clock enable
//   mode_i               operation select
//   pin_i                parallel load data
//   sin_l_i, sin_r_i     serial inputs for shift-left / shift-right
//   start_i, count_i     burst request and step count
//   pout_o               register contents
//   sout_l_o, sout_r_o   MSB / LSB of the register
//   busy_o, done_o       burst status
module universal_shift_reg
  import universal_shift_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [2:0]       mode_i,
  input  logic [WIDTH-1:0] pin_i,
  input  logic             sin_l_i,
  input  logic             sin_r_i,
  input  logic             start_i,
  input  logic [CW-1:0]    count_i,
  output logic [WIDTH-1:0] pout_o,
  output logic             sout_l_o,
  output logic             sout_r_o,
  output logic             busy_o,
  output logic             done_o
);

  logic [WIDTH-1:0] pout_q, pout_d;
  logic [2:0]       op;

  shift_burst_ctrl #(.CW(CW)) u_ctrl (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .en_i    (en_i),
    .mode_i  (mode_i),
    .start_i (start_i),
    .count_i (count_i),
    .op_o    (op),
    .busy_o  (busy_o),
    .done_o  (done_o)
  );

  always_comb begin
    pout_d = pout_q;
    case (op)
      MODE_SHL:  pout_d = {pout_q[WIDTH-2:0], sin_l_i};
      MODE_SHR:  pout_d = {sin_r_i, pout_q[WIDTH-1:1]};
      MODE_LOAD: pout_d = pin_i;
      MODE_ROL:  pout_d = {pout_q[WIDTH-2:0], pout_q[WIDTH-1]};
      MODE_ROR:  pout_d = {pout_q[0], pout_q[WIDTH-1:1]};
      MODE_CLR:  pout_d = '0;
      default:   pout_d = pout_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) pout_q <= '0;
    else       pout_q <= pout_d;
  end

  assign pout_o   = pout_q;
  assign sout_l_o = pout_q[WIDTH-1];
  assign sout_r_o = pout_q[0];

endmodule

// File: tb/tb_universal_shift_reg.sv
// tb/tb_universal_shift_reg.sv - self-checking bench for universal_shift_reg (4- and 8-bit)
module tb_universal_shift_reg;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0, start = 1'b0, sin_l = 1'b0, sin_r = 1'b0;
  logic [2:0] mode = 3'd0;
  logic [7:0] pin = 8'd0;
  logic [3:0] count = 4'd0;

  logic [3:0] pout4;
  logic [7:0] pout8;
  logic       soutl4, soutr4, busy4, done4;
  logic       soutl8, soutr8, busy8, done8;

  int errors = 0;
  int checks = 0;

  int mval[2], mrem[2], mbm[2];
  bit mbusy[2], mdone[2];
  int wid[2] = '{4, 8};

  always #5 clk = ~clk;

  universal_shift_reg #(.WIDTH(4)) u4 (
    .clk_i(clk), .rst_i(rst), .en_i(en), .mode_i(mode), .pin_i(pin[3:0]),
    .sin_l_i(sin_l), .sin_r_i(sin_r), .start_i(start), .count_i(count[2:0]),
    .pout_o(pout4), .sout_l_o(soutl4), .sout_r_o(soutr4), .busy_o(busy4), .done_o(done4)
  );

  universal_shift_reg #(.WIDTH(8)) u8 (
    .clk_i(clk), .rst_i(rst), .en_i(en), .mode_i(mode), .pin_i(pin),
    .sin_l_i(sin_l), .sin_r_i(sin_r), .start_i(start), .count_i(count),
    .pout_o(pout8), .sout_l_o(soutl8), .sout_r_o(soutr8), .busy_o(busy8), .done_o(done8)
  );

  function automatic int apply_op(int op, int v, int w, int p, bit sl, bit sr);
    int mask;
    mask = (1 << w) - 1;
    case (op)
      1: return ((v << 1) | int'(sl)) & mask;
      2: return (v >> 1) | (int'(sr) << (w - 1));
      3: return p & mask;
      4: return ((v << 1) | (v >> (w - 1))) & mask;
      5: return (v >> 1) | ((v & 1) << (w - 1));
      6: return 0;
      default: return v;
    endcase
  endfunction

  function automatic bit burstable(int op);
    return (op == 1) || (op == 2) || (op == 4) || (op == 5);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mval[i] = 0; mrem[i] = 0; mbm[i] = 0; mbusy[i] = 0; mdone[i] = 0;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_u4_pout"},  32'(pout4),  mval[0]);
    chk({tag, "_u4_soutl"}, 32'(soutl4), (mval[0] >> 3) & 1);
    chk({tag, "_u4_soutr"}, 32'(soutr4), mval[0] & 1);
    chk({tag, "_u4_busy"},  32'(busy4),  32'(mbusy[0]));
    chk({tag, "_u4_done"},  32'(done4),  32'(mdone[0]));
    chk({tag, "_u8_pout"},  32'(pout8),  mval[1]);
    chk({tag, "_u8_soutl"}, 32'(soutl8), (mval[1] >> 7) & 1);
    chk({tag, "_u8_soutr"}, 32'(soutr8), mval[1] & 1);
    chk({tag, "_u8_busy"},  32'(busy8),  32'(mbusy[1]));
    chk({tag, "_u8_done"},  32'(done8),  32'(mdone[1]));
  endtask

  // Predict one clock edge from the inputs currently driven, then check after the edge.
  task automatic tick(input string tag);
    int nval[2], nrem[2], nbm[2];
    bit nbusy[2], ndone[2];
    for (int i = 0; i < 2; i++) begin
      int c;
      c = (i == 0) ? (int'(count) & 7) : int'(count);
      nval[i] = mval[i]; nrem[i] = mrem[i]; nbm[i] = mbm[i];
      nbusy[i] = mbusy[i]; ndone[i] = 1'b0;
      if (mdone[i]) begin
        ndone[i] = 1'b0;
      end else if (mbusy[i]) begin
        if (en) begin
          nval[i] = apply_op(mbm[i], mval[i], wid[i], int'(pin), sin_l, sin_r);
          nrem[i] = mrem[i] - 1;
          if (nrem[i] == 0) begin
            nbusy[i] = 1'b0;
            ndone[i] = 1'b1;
          end
        end
      end else if (en) begin
        if (start && c != 0 && burstable(int'(mode))) begin
          nbusy[i] = 1'b1; nrem[i] = c; nbm[i] = int'(mode);
        end else begin
          nval[i] = apply_op(int'(mode), mval[i], wid[i], int'(pin), sin_l, sin_r);
        end
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      mval[i] = nval[i]; mrem[i] = nrem[i]; mbm[i] = nbm[i];
      mbusy[i] = nbusy[i]; mdone[i] = ndone[i];
    end
    check_all(tag);
  endtask

  // Assert reset between edges and verify the register clears without a clock edge.
  task automatic areset(input string tag);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_all("reset");

    // Direct load then asynchronous reset.
    en = 1'b1; mode = 3'b011; pin = 8'hCA;
    tick("load");
    chk("load_u4_const", 32'(pout4), 32'hA);
    areset("areset");
    chk("areset_u4_const", 32'(pout4), 32'h0);

    // Direct mode walk.
    mode = 3'b011; pin = 8'hCA; tick("load2");
    mode = 3'b001; sin_l = 1'b1; tick("shl");
    chk("shl_u4_const", 32'(pout4), 32'h5);
    mode = 3'b010; sin_r = 1'b1; tick("shr");
    chk("shr_u4_const", 32'(pout4), 32'hA);
    mode = 3'b100; tick("rol");
    chk("rol_u4_const", 32'(pout4), 32'h5);
    mode = 3'b101; tick("ror");
    chk("ror_u4_const", 32'(pout4), 32'hA);
    mode = 3'b110; tick("clr");
    chk("clr_u4_const", 32'(pout4), 32'h0);
    mode = 3'b011; pin = 8'h96; tick("load3");
    mode = 3'b111; tick("rsvd");
    chk("rsvd_u4_const", 32'(pout4), 32'h6);
    sin_l = 1'b0; sin_r = 1'b0;

    // Rotate burst of 4 returns the 4-bit value to its start.
    mode = 3'b011; pin = 8'h0B; tick("load_b");
    mode = 3'b100; count = 4'd4; start = 1'b1; tick("rol_start");
    chk("rol_start_busy", 32'(busy4), 32'h1);
    start = 1'b0; mode = 3'b110;
    for (int k = 0; k < 4; k++) tick("rol_step");
    chk("rol_end_u4_const", 32'(pout4), 32'hB);
    chk("rol_end_done", 32'(done4), 32'h1);
    tick("rol_after");
    chk("rol_after_busy", 32'(busy4), 32'h0);

    // 8-bit deserialize 0xA5 LSB-first over an SHR burst with mode toggling.
    mode = 3'b110; tick("clr8");
    mode = 3'b010; count = 4'd8; start = 1'b1; tick("shr_start");
    start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      logic [7:0] pat;
      pat = 8'hA5;
      sin_r = pat[k];
      mode = 3'($urandom_range(0, 7));
      tick("shr_step");
    end
    chk("deser_u8_const", 32'(pout8), 32'hA5);
    chk("deser_u8_done", 32'(done8), 32'h1);
    mode = 3'b000; tick("deser_after");

    // Burst of 3 SHL with a two-cycle stall; start during DONE is ignored.
    mode = 3'b001; count = 4'd3; sin_l = 1'b1; start = 1'b1; tick("stall_start");
    start = 1'b0; mode = 3'b000;
    tick("stall_s1");
    en = 1'b0; tick("stall_e0a"); tick("stall_e0b");
    en = 1'b1; tick("stall_s2"); tick("stall_s3");
    chk("stall_done", 32'(done8), 32'h1);
    mode = 3'b001; count = 4'd2; start = 1'b1; tick("done_start");
    chk("done_start_busy", 32'(busy8), 32'h0);
    start = 1'b0; mode = 3'b000; tick("post_done");

    // Reset aborts a burst; a new burst then runs; count=0 start is a plain load.
    mode = 3'b001; count = 4'd5; start = 1'b1; tick("abort_start");
    start = 1'b0; mode = 3'b000;
    tick("abort_s1"); tick("abort_s2");
    areset("abort_rst");
    chk("abort_busy", 32'(busy8), 32'h0);
    tick("abort_idle");
    chk("abort_nodone", 32'(done8), 32'h0);
    mode = 3'b101; count = 4'd2; start = 1'b1; tick("restart");
    chk("restart_busy", 32'(busy4), 32'h1);
    start = 1'b0; mode = 3'b000;
    tick("restart_s1"); tick("restart_s2"); tick("restart_done");
    mode = 3'b011; count = 4'd0; pin = 8'h3C; start = 1'b1; tick("cnt0_load");
    chk("cnt0_busy", 32'(busy8), 32'h0);
    chk("cnt0_u8_const", 32'(pout8), 32'h3C);
    start = 1'b0;

    // Randomised traffic against the reference model.
    for (int k = 0; k < 400; k++) begin
      en    = ($urandom_range(0, 7) != 0);
      mode  = 3'($urandom_range(0, 7));
      start = ($urandom_range(0, 3) == 0);
      count = 4'($urandom_range(0, 7));
      pin   = 8'($urandom);
      sin_l = 1'($urandom);
      sin_r = 1'($urandom);
      tick("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
